// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: queues command bytes and clocks them out
// with inhibit, request-to-send, odd parity, stop and ACK check on open-drain pads.
module ps2_host_tx #(
   parameter int FIFO_DEPTH     = 8,
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 750000
) (
   input  logic       msoc_clk,
   input  logic       rstn,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   input  logic       ps2_clk_i,
   input  logic       ps2_data_i,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   output logic       rx_inhibit,
   output logic       busy,
   output logic       tx_done,
   output logic       tx_error_no_keyboard_ack,
   output logic [2:0] dbg_state
);
   // Handshake: a byte is taken on any rising edge where tx_valid && tx_ready;
   // tx_valid may be raised without waiting for tx_ready.

   typedef enum logic [2:0] {
      IDLE, INHIBIT, REQ, DATA, PARITY, STOP, WAIT_IDLE
   } state_t;

   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam int CMAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
   localparam int CW   = $clog2(CMAX + 1);
   localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES);
   localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

   state_t          state, state_next;
   logic [7:0]      mem [FIFO_DEPTH];
   logic [AW:0]     wr_ptr, rd_ptr;
   logic            empty, full, push, pop;
   logic [CW-1:0]   cyc_cnt;
   logic [7:0]      sr;
   logic            parity, drive_bit, err;
   logic [3:0]      bitcnt;
   logic            clk_s1, clk_sync, clk_sync_q, data_s1, data_sync;
   logic            fall, lines_high, in_frame, timeout;

   always_ff @(posedge msoc_clk) begin
      if (!rstn) begin
         clk_s1     <= 1'b1;
         clk_sync   <= 1'b1;
         clk_sync_q <= 1'b1;
         data_s1    <= 1'b1;
         data_sync  <= 1'b1;
      end else begin
         clk_s1     <= ps2_clk_i;
         clk_sync   <= clk_s1;
         clk_sync_q <= clk_sync;
         data_s1    <= ps2_data_i;
         data_sync  <= data_s1;
      end
   end

   assign fall       = clk_sync_q & ~clk_sync;
   assign lines_high = clk_sync & data_sync;

   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign tx_ready = ~full;
   assign push     = tx_valid & ~full;

   assign in_frame = (state == REQ) || (state == DATA) || (state == PARITY) || (state == STOP);
   assign timeout  = in_frame && (cyc_cnt == TO_LAST);

   always_comb begin
      state_next  = state;
      ps2_clk_oe  = 1'b0;
      ps2_data_oe = 1'b0;
      pop         = 1'b0;
      tx_done     = 1'b0;
      case (state)
         IDLE: begin
            if (!empty) begin
               state_next = INHIBIT;
               pop        = 1'b1;
            end
         end
         INHIBIT: begin
            ps2_clk_oe = 1'b1;
            // Start bit is asserted for one cycle while the clock is still held low.
            if (cyc_cnt == INH_LAST) begin
               ps2_data_oe = 1'b1;
               state_next  = REQ;
            end
         end
         REQ: begin
            ps2_data_oe = 1'b1;
            if (fall) state_next = DATA;
         end
         DATA: begin
            ps2_data_oe = ~drive_bit;
            if (fall && bitcnt == 4'd8) state_next = PARITY;
         end
         PARITY: begin
            ps2_data_oe = ~drive_bit;
            if (fall) state_next = STOP;
         end
         STOP: begin
            if (fall) state_next = WAIT_IDLE;
         end
         WAIT_IDLE: begin
            if (lines_high) begin
               state_next = IDLE;
               tx_done    = ~err;
            end
         end
         default: state_next = IDLE;
      endcase
      if (timeout) state_next = IDLE;
   end

   always_ff @(posedge msoc_clk) begin
      if (!rstn) begin
         state     <= IDLE;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         cyc_cnt   <= '0;
         sr        <= '0;
         parity    <= 1'b0;
         drive_bit <= 1'b1;
         bitcnt    <= '0;
         err       <= 1'b0;
      end else begin
         state <= state_next;
         if (push) begin
            mem[wr_ptr[AW-1:0]] <= tx_data;
            wr_ptr              <= wr_ptr + 1'b1;
         end
         if (in_frame) cyc_cnt <= cyc_cnt + 1'b1;
         case (state)
            IDLE: begin
               if (pop) begin
                  rd_ptr  <= rd_ptr + 1'b1;
                  sr      <= mem[rd_ptr[AW-1:0]];
                  parity  <= ~^mem[rd_ptr[AW-1:0]];
                  bitcnt  <= '0;
                  err     <= 1'b0;
                  cyc_cnt <= '0;
               end
            end
            INHIBIT: cyc_cnt <= (cyc_cnt == INH_LAST) ? '0 : cyc_cnt + 1'b1;
            REQ: if (fall) begin
               drive_bit <= sr[0];
               sr        <= sr >> 1;
               bitcnt    <= 4'd1;
            end
            DATA: if (fall) begin
               if (bitcnt == 4'd8) begin
                  drive_bit <= parity;
               end else begin
                  drive_bit <= sr[0];
                  sr        <= sr >> 1;
                  bitcnt    <= bitcnt + 4'd1;
               end
            end
            PARITY: if (fall) drive_bit <= 1'b1;
            STOP:   if (fall && data_sync) err <= 1'b1;
            default: ;
         endcase
         if (timeout) err <= 1'b1;
      end
   end

   assign rx_inhibit               = (state != IDLE);
   assign busy                     = ~empty | (state != IDLE);
   assign tx_error_no_keyboard_ack = err;
   assign dbg_state                = state;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus plus a behavioural keyboard that clocks
// frames, samples host bits, and ACKs or NACKs on the 11th falling edge.
module tb_ps2_host_tx;
   localparam int INH  = 20;
   localparam int TO   = 2000;
   localparam int HALF = 30;

   logic       msoc_clk = 1'b0;
   logic       rstn = 1'b0;
   logic       tx_valid = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_ready, ps2_clk_oe, ps2_data_oe, rx_inhibit, busy, tx_done, tx_err;
   logic [2:0] dbg_state;
   logic       ps2_clk_i, ps2_data_i;
   logic       dev_clk_low = 1'b0, dev_data_low = 1'b0;

   int checks = 0;
   int failures = 0;
   int done_cnt = 0;
   logic [7:0] exp_q[$];

   typedef struct {
      logic [7:0] data;
      logic       ack;
      logic [9:0] exp_bits;
      logic       exp_done;
      logic       exp_err;
   } vec_t;
   vec_t vecs[6];

   assign ps2_clk_i  = ~(ps2_clk_oe | dev_clk_low);
   assign ps2_data_i = ~(ps2_data_oe | dev_data_low);

   ps2_host_tx #(.FIFO_DEPTH(8), .INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
      .msoc_clk(msoc_clk), .rstn(rstn), .tx_valid(tx_valid), .tx_data(tx_data),
      .tx_ready(tx_ready), .ps2_clk_i(ps2_clk_i), .ps2_data_i(ps2_data_i),
      .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe), .rx_inhibit(rx_inhibit),
      .busy(busy), .tx_done(tx_done), .tx_error_no_keyboard_ack(tx_err),
      .dbg_state(dbg_state)
   );

   always #5 msoc_clk = ~msoc_clk;

   always @(negedge msoc_clk) if (tx_done) done_cnt++;

   initial begin
      #1000000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge msoc_clk);
      #1;
   endtask

   task automatic push(input logic [7:0] b);
      @(negedge msoc_clk);
      tx_valid = 1'b1;
      tx_data  = b;
      @(posedge msoc_clk);
      #1;
      tx_valid = 1'b0;
   endtask

   task automatic wait_request(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 5000; i++) begin
         if (ps2_clk_i && !ps2_data_i && !ps2_clk_oe) begin
            ok = 1'b1;
            break;
         end
         tick(1);
      end
      check("request_seen", {31'd0, ok}, 32'd1);
   endtask

   task automatic wait_idle();
      bit ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if (!busy) begin
            ok = 1'b1;
            break;
         end
         tick(1);
      end
      check("busy_drops", {31'd0, ok}, 32'd1);
   endtask

   task automatic dev_frame(input logic ack, output logic [9:0] bits);
      bit ok;
      bits = '0;
      wait_request(ok);
      if (!ok) return;
      for (int i = 0; i < 10; i++) begin
         tick(HALF);
         dev_clk_low = 1'b1;
         tick(HALF);
         bits[i] = ps2_data_i;
         dev_clk_low = 1'b0;
      end
      tick(HALF / 2);
      dev_data_low = ack;
      tick(HALF / 2);
      dev_clk_low = 1'b1;
      tick(HALF);
      dev_clk_low = 1'b0;
      tick(HALF);
      dev_data_low = 1'b0;
   endtask

   initial begin
      logic [9:0] bits;
      logic [7:0] exp_b;
      bit         ok;
      int         n;
      int         accepted;

      // {data, ack, {stop, parity, data}, done, error}
      vecs[0] = '{8'hED, 1'b1, 10'h3ED, 1'b1, 1'b0};
      vecs[1] = '{8'h00, 1'b1, 10'h300, 1'b1, 1'b0};
      vecs[2] = '{8'h01, 1'b1, 10'h201, 1'b1, 1'b0};
      vecs[3] = '{8'hA5, 1'b0, 10'h3A5, 1'b0, 1'b1};
      vecs[4] = '{8'h07, 1'b1, 10'h207, 1'b1, 1'b0};
      vecs[5] = '{8'hFF, 1'b1, 10'h3FF, 1'b1, 1'b0};

      tick(3);
      check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
      check("rst_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
      check("rst_data_oe", {31'd0, ps2_data_oe}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_rx_inhibit", {31'd0, rx_inhibit}, 32'd0);
      check("rst_tx_done", {31'd0, tx_done}, 32'd0);
      check("rst_error", {31'd0, tx_err}, 32'd0);
      rstn = 1'b1;
      tick(4);

      for (int v = 0; v < 6; v++) begin
         done_cnt = 0;
         push(vecs[v].data);
         check($sformatf("v%0d_clk_oe_after_push", v), {31'd0, ps2_clk_oe}, 32'd0);
         tick(1);
         check($sformatf("v%0d_clk_oe_latency", v), {31'd0, ps2_clk_oe}, 32'd1);
         check($sformatf("v%0d_error_cleared", v), {31'd0, tx_err}, 32'd0);
         check($sformatf("v%0d_rx_inhibit", v), {31'd0, rx_inhibit}, 32'd1);
         dev_frame(vecs[v].ack, bits);
         wait_idle();
         tick(2);
         check($sformatf("v%0d_bits", v), {22'd0, bits}, {22'd0, vecs[v].exp_bits});
         check($sformatf("v%0d_done_count", v), done_cnt, {31'd0, vecs[v].exp_done});
         check($sformatf("v%0d_error", v), {31'd0, tx_err}, {31'd0, vecs[v].exp_err});
      end

      // Silent keyboard: error lands exactly TO cycles after REQ entry.
      done_cnt = 0;
      push(8'h55);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         tick(1);
         if (!ps2_clk_oe && ps2_data_oe) begin
            ok = 1'b1;
            break;
         end
      end
      check("to_req_entered", {31'd0, ok}, 32'd1);
      n = 0;
      for (int i = 0; i < TO + 100; i++) begin
         tick(1);
         n++;
         if (tx_err) break;
      end
      check("to_cycles", n, TO);
      check("to_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
      check("to_data_oe", {31'd0, ps2_data_oe}, 32'd0);
      check("to_busy", {31'd0, busy}, 32'd0);
      check("to_rx_inhibit", {31'd0, rx_inhibit}, 32'd0);
      check("to_done_count", done_cnt, 0);

      // Nine back-to-back pushes; the first pops immediately so the rest fill the FIFO.
      done_cnt = 0;
      accepted = 0;
      for (int i = 0; i < 9; i++) begin
         @(negedge msoc_clk);
         tx_valid = 1'b1;
         tx_data  = 8'h30 + 8'(i * 7);
         if (tx_ready) begin
            exp_q.push_back(tx_data);
            accepted++;
         end
         @(posedge msoc_clk);
      end
      #1;
      tx_valid = 1'b0;
      check("fifo_accepted", accepted, 9);
      check("fifo_full_ready_low", {31'd0, tx_ready}, 32'd0);
      for (int k = 0; k < 9; k++) begin
         dev_frame(1'b1, bits);
         exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
         check($sformatf("fifo_byte%0d", k), {24'd0, bits[7:0]}, {24'd0, exp_b});
      end
      wait_idle();
      tick(2);
      check("fifo_done_count", done_cnt, 9);
      check("fifo_error", {31'd0, tx_err}, 32'd0);

      // Reset in the middle of the data bits with a second byte still queued.
      done_cnt = 0;
      push(8'hC3);
      push(8'h3C);
      wait_request(ok);
      for (int i = 0; i < 4; i++) begin
         tick(HALF);
         dev_clk_low = 1'b1;
         tick(HALF);
         dev_clk_low = 1'b0;
      end
      check("mid_state_data", {29'd0, dbg_state}, 32'd3);
      rstn = 1'b0;
      tick(1);
      check("mid_rst_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
      check("mid_rst_data_oe", {31'd0, ps2_data_oe}, 32'd0);
      check("mid_rst_busy", {31'd0, busy}, 32'd0);
      check("mid_rst_tx_ready", {31'd0, tx_ready}, 32'd1);
      check("mid_rst_rx_inhibit", {31'd0, rx_inhibit}, 32'd0);
      check("mid_rst_error", {31'd0, tx_err}, 32'd0);
      rstn = 1'b1;
      tick(5);
      check("post_rst_busy", {31'd0, busy}, 32'd0);
      check("post_rst_done_count", done_cnt, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
